hazard_scoreboard_unit: RTL
===========================

# hazard_scoreboard_unit

Parametrised next-generation hazard unit for the five-stage pipelined core. It generates E-stage and D-stage forwarding selects, load-use and branch stalls, and D-stage flushes on taken branches and jumps. It also keeps a scoreboard for one multi-cycle multiply/divide unit (MDU) with programmable latency, and a saturating stall-cycle counter. It sits beside the datapath and control unit in the core top.

## Interface
- ADDR_W, 5: register index width (2**ADDR_W architectural registers; index 0 is hard-wired zero).
- MDU_LAT, 4: MDU latency in cycles, ≥1.
- STALL_CNT_W, 16: stall counter width.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RsD, RtD  in  ADDR_W  decode source registers.
- UsesRsD, UsesRtD  in  1  decode instruction actually reads Rs / Rt.
- BranchD, JumpD, PCSrcD  in  1  branch in D / jump in D / branch taken.
- MduOpD  in  1  decode instruction is an MDU op.
- RsE, RtE, WriteRegE  in  ADDR_W  E-stage sources / destination.
- RegWriteE, MemtoRegE  in  1  E-stage writes a register / is a load.
- MduStartE  in  1  MDU op issuing from E this cycle.
- MduDestE  in  ADDR_W  MDU destination register.
- WriteRegM, WriteRegW  in  ADDR_W  M- and W-stage destinations.
- RegWriteM, MemtoRegM, RegWriteW  in  1  M/W write enables; M-stage load.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result.
- ForwardAD, ForwardBD  out  1  forward M ALU result to the branch comparator.
- StallF, StallD, FlushE, FlushD  out  1  pipeline control.
- MduBusy, MduDone  out  1  scoreboard status.
- StallCount  out  STALL_CNT_W  saturating count of stall cycles.

## Operation
- **E-stage forwarding (Rs side).**
  - ForwardAE = 10 if RsE≠0 && RegWriteM && WriteRegM==RsE.
  - Else 01 if RsE≠0 && RegWriteW && WriteRegW==RsE.
  - Else 00.
  - M takes priority over W. ForwardBE is identical using RtE.
- **D-stage forwarding.** ForwardAD = RsD≠0 && RegWriteM && WriteRegM==RsD. ForwardBD is the same using RtD.
- **Match terms.** matchD(x) = x≠0 && ((UsesRsD && RsD==x) || (UsesRtD && RtD==x)).
- **lwstall** = MemtoRegE && matchD(WriteRegE).
- **branchstall** = BranchD && ((RegWriteE && matchD(WriteRegE)) || (MemtoRegM && matchD(WriteRegM))).
- **MDU scoreboard.**
  - State: MduBusy, MduDest (ADDR_W), counter cnt (ceil(log2 MDU_LAT)+1 bits).
  - IDLE → BUSY on MduStartE: MduBusy←1, MduDest←MduDestE, cnt←MDU_LAT−1.
  - BUSY: if cnt==0, MduBusy←0; else cnt←cnt−1.
  - MduDone = MduBusy && cnt==0 (combinational). The MDU writes the register file in that cycle.
  - The register file is write-first, so a D-stage reader needs no stall in the MduDone cycle.
  - MduStartE while BUSY and not MduDone is a protocol violation. mdustall prevents it.
- **mdustall** is the OR of:
  - dependency: MduBusy && !MduDone && matchD(MduDest);
  - dependency: MduStartE && matchD(MduDestE);
  - structural: MduOpD && ((MduBusy && !MduDone) || MduStartE).
- **Stall and flush.**
  - stall = lwstall | branchstall | mdustall.
  - StallF = StallD = FlushE = stall.
  - FlushD = (PCSrcD | JumpD) & !stall.
- **StallCount:** increments by 1 on every cycle with stall=1, holds at 2**STALL_CNT_W−1.
- **Reset (RST=1 at an edge):** MduBusy←0, MduDest←0, cnt←0, StallCount←0.
  - RST during BUSY abandons the operation; no MduDone is produced.
  - Combinational outputs follow their inputs while RST is high. With all inputs 0, every output is 0.

## Timing
- Forward*, Stall*, Flush*, MduDone: combinational from current inputs and state; zero latency.
- MduBusy rises on the edge after MduStartE and stays high exactly MDU_LAT cycles.
- MduDone is high in the last of those cycles.
- MDU_LAT=1: MduBusy and MduDone both high for exactly the one cycle after MduStartE.
- Back-to-back MDU ops: MduStartE in the MduDone cycle is legal. It reloads cnt and keeps MduBusy high with no gap.
- StallCount reflects a stall cycle on the following edge.

## Test plan
- **Load-use:** MemtoRegE=1, WriteRegE=5, RsD=5, UsesRsD=1 → StallF=StallD=FlushE=1, FlushD=0; StallCount 0→1 after one edge.
- **Forward priority:** RsE=3, RegWriteM=1, WriteRegM=3, RegWriteW=1, WriteRegW=3 → ForwardAE=10.
  - Drop RegWriteM → ForwardAE=01.
  - RsE=0 → ForwardAE=00.
- **Branch hazard:** BranchD=1, RtD=7, UsesRtD=1, RegWriteE=1, WriteRegE=7 → stall=1.
  - Next case, WriteRegM=7, RegWriteM=1, MemtoRegM=0 → stall=0, ForwardBD=1.
- **MDU, MDU_LAT=4:** MduStartE with MduDestE=9, and D reads r9 → stall in the start cycle and the next 3 cycles.
  - MduDone in cycle 4 after start, stall=0 there; MduBusy=0 afterwards.
  - MduOpD during BUSY → stall until MduDone.
- **Jump flush and reset:**
  - JumpD=1, no hazard → FlushD=1.
  - JumpD=1 with lwstall → FlushD=0.
  - RST mid-BUSY → MduBusy=0 and StallCount=0 next cycle; MduDone never asserts.
- **Saturation:** STALL_CNT_W=4, hold stall 20 cycles → StallCount reaches 15 and stays 15.

Source files
------------

// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard-unit signal bundle between the pipeline (master) and the hazard unit (slave).
interface hazard_scoreboard_unit_if #(
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
);
    logic [ADDR_W-1:0]      RsD, RtD;
    logic                   UsesRsD, UsesRtD;
    logic                   BranchD, JumpD, PCSrcD, MduOpD;
    logic [ADDR_W-1:0]      RsE, RtE, WriteRegE;
    logic                   RegWriteE, MemtoRegE, MduStartE;
    logic [ADDR_W-1:0]      MduDestE;
    logic [ADDR_W-1:0]      WriteRegM, WriteRegW;
    logic                   RegWriteM, MemtoRegM, RegWriteW;
    logic [1:0]             ForwardAE, ForwardBE;
    logic                   ForwardAD, ForwardBD;
    logic                   StallF, StallD, FlushE, FlushD;
    logic                   MduBusy, MduDone;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output RsD, RtD, UsesRsD, UsesRtD, BranchD, JumpD, PCSrcD, MduOpD,
               RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MduStartE, MduDestE,
               WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, FlushD, MduBusy, MduDone, StallCount
    );

    modport slave (
        input  RsD, RtD, UsesRsD, UsesRtD, BranchD, JumpD, PCSrcD, MduOpD,
               RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, MduStartE, MduDestE,
               WriteRegM, WriteRegW, RegWriteM, MemtoRegM, RegWriteW,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, FlushD, MduBusy, MduDone, StallCount
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding, stall/flush generation, MDU result scoreboard and saturating stall counter.
// state    | meaning
// MDU_IDLE | no MDU op in flight
// MDU_BUSY | MDU op in flight, cnt_q counts down to the write-back cycle
module hazard_scoreboard_unit #(
    parameter int ADDR_W      = 5,
    parameter int MDU_LAT     = 4,
    parameter int STALL_CNT_W = 16
) (
    input logic                     CLK,
    input logic                     RST,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int CNT_W = $clog2(MDU_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_t;

    mdu_state_t             state_q;
    logic [ADDR_W-1:0]      mdu_dest_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mdu_busy, mdu_done, mdu_pend;
    logic lwstall, branchstall, mdustall, stall;

    function automatic logic match_d(input logic [ADDR_W-1:0] x,
                                     input logic [ADDR_W-1:0] rs,
                                     input logic [ADDR_W-1:0] rt,
                                     input logic use_rs,
                                     input logic use_rt);
        return (x != '0) && ((use_rs && rs == x) || (use_rt && rt == x));
    endfunction

    assign hz.ForwardAE = (hz.RsE != '0 && hz.RegWriteM && hz.WriteRegM == hz.RsE) ? 2'b10 :
                          (hz.RsE != '0 && hz.RegWriteW && hz.WriteRegW == hz.RsE) ? 2'b01 : 2'b00;
    assign hz.ForwardBE = (hz.RtE != '0 && hz.RegWriteM && hz.WriteRegM == hz.RtE) ? 2'b10 :
                          (hz.RtE != '0 && hz.RegWriteW && hz.WriteRegW == hz.RtE) ? 2'b01 : 2'b00;
    assign hz.ForwardAD = (hz.RsD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
    assign hz.ForwardBD = (hz.RtD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);

    assign mdu_busy = (state_q == MDU_BUSY);
    assign mdu_done = mdu_busy && (cnt_q == '0);
    assign mdu_pend = mdu_busy && !mdu_done;

    assign lwstall = hz.MemtoRegE &&
                     match_d(hz.WriteRegE, hz.RsD, hz.RtD, hz.UsesRsD, hz.UsesRtD);
    assign branchstall = hz.BranchD &&
        ((hz.RegWriteE && match_d(hz.WriteRegE, hz.RsD, hz.RtD, hz.UsesRsD, hz.UsesRtD)) ||
         (hz.MemtoRegM && match_d(hz.WriteRegM, hz.RsD, hz.RtD, hz.UsesRsD, hz.UsesRtD)));
    // The done cycle needs no stall: the register file forwards the write to the reader.
    assign mdustall =
        (mdu_pend && match_d(mdu_dest_q, hz.RsD, hz.RtD, hz.UsesRsD, hz.UsesRtD)) ||
        (hz.MduStartE && match_d(hz.MduDestE, hz.RsD, hz.RtD, hz.UsesRsD, hz.UsesRtD)) ||
        (hz.MduOpD && (mdu_pend || hz.MduStartE));
    assign stall = lwstall | branchstall | mdustall;

    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushE     = stall;
    assign hz.FlushD     = (hz.PCSrcD | hz.JumpD) & ~stall;
    assign hz.MduBusy    = mdu_busy;
    assign hz.MduDone    = mdu_done;
    assign hz.StallCount = stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= MDU_IDLE;
            mdu_dest_q <= '0;
            cnt_q      <= '0;
        end else if (hz.MduStartE) begin
            state_q    <= MDU_BUSY;
            mdu_dest_q <= hz.MduDestE;
            cnt_q      <= CNT_LOAD;
        end else if (state_q == MDU_BUSY) begin
            if (cnt_q == '0) begin
                state_q <= MDU_IDLE;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign stall_cnt_d = (stall && stall_cnt_q != STALL_MAX) ?
                         stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
